mem_access: RTL
===============

# mem_access

Memory-access stage of the RV32I pipeline, sitting between execute and write-back. It passes ALU results through for non-memory instructions, performs loads and stores against a single-ported data memory with a request/acknowledge handshake, and aligns and sign-extends load data. It drives the instruction/result pair consumed by write-back and stalls upstream stages while a memory transaction is outstanding.

## Interface

Parameters:

- `XLEN`, from `define.sv`, must be 32. Data width.
- `NOP`, 32'h0000_0013. Instruction emitted in place of dropped instructions.

Ports:

- `clk`  in  1  Single clock, rising edge.
- `rst`  in  1  Synchronous, active-high reset.
- `valid_in`  in  1  An instruction is presented by execute.
- `instruction_in`  in  XLEN  Instruction word from execute.
- `alu_in`  in  XLEN  ALU result; this is the effective address for loads and stores.
- `store_data_in`  in  XLEN  rs2 value for stores.
- `taken_branch`  in  1  Squash the presented instruction.
- `halt`  out  1  Stall request to upstream stages.
- `dmem_req`  out  1  Memory request valid.
- `dmem_we`  out  1  1 = store, 0 = load.
- `dmem_addr`  out  XLEN  Word-aligned address, i.e. `{alu_in[31:2], 2'b00}`.
- `dmem_be`  out  4  Byte enables.
- `dmem_wdata`  out  XLEN  Store data, replicated into byte lanes.
- `dmem_ack`  in  1  Memory completes the request this cycle.
- `dmem_rdata`  in  XLEN  Read word, valid when `dmem_ack` is 1.
- `valid_out`  out  1  Output pair is valid.
- `instruction_out`  out  XLEN  Instruction sent to write-back.
- `result_out`  out  XLEN  Value to be written to rd.
- `misalign_err`  out  1  One-cycle pulse when a misaligned access is dropped.

## Operation

- The state machine has two states, IDLE and BUSY. `rst` forces IDLE.
- **Accept.** In IDLE, the stage accepts when `valid_in` is 1 and `taken_branch` is 0.
- **Squash.** When `valid_in` and `taken_branch` are both 1, the stage emits `NOP` with `valid_out` = 1 and `result_out` = 0.
- **Non-memory opcodes.** `instruction_out` = `instruction_in` and `result_out` = `alu_in`. The state stays IDLE.
- **LOAD and STORE opcodes.** `funct3` = `instruction_in[14:12]` and the byte offset is `alu_in[1:0]`.
- **Alignment.**
  - Byte accesses are always aligned.
  - Halfword accesses require offset[0] = 0.
  - Word accesses require offset = 0.
  - `funct3` values that are illegal for the opcode are treated as misaligned.
- **Misaligned access.** No request is issued. `misalign_err` pulses and `NOP` is emitted with `result_out` = 0. The state stays IDLE.
- **Aligned access.** The stage latches the instruction, offset, `funct3`, byte enables and write data, then goes to BUSY.
- **Byte enables.** Byte = `4'b0001 << off`. Halfword = `4'b0011 << off`. Word = `4'b1111`.
- **Store data.** SB replicates `rs2[7:0]` ×4. SH replicates `rs2[15:0]` ×2. SW uses `rs2` unchanged.
- **BUSY.**
  - `dmem_req` = 1 and `halt` = 1. `dmem_*` fields are held stable until `dmem_ack`.
  - On `dmem_ack` the stage returns to IDLE and registers its outputs.
  - LB and LH sign-extend the selected lane; LBU and LHU zero-extend it; LW passes the word.
  - For stores, `result_out` = 0.
  - `instruction_out` is the latched instruction.
- **`taken_branch` while BUSY.** Ignored; the in-flight access always completes.
- **Reset mid-transaction.** `dmem_req` drops in the same cycle the reset is sampled and no output is produced. The memory must tolerate an abandoned request.

## Timing

- Reset values of every output are 0: `halt`, `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_be`, `dmem_wdata`, `valid_out`, `result_out` and `misalign_err`. The exception is `instruction_out`, which resets to `NOP`.
- **Non-memory, squash and misaligned cases.** Outputs appear one cycle after accept. `valid_out` stays high for one cycle.
- **Memory access.**
  - Accept at edge N.
  - `dmem_req` and `halt` are high from N+1.
  - With ack sampled at edge N+k (k ≥ 1), `valid_out` and `result_out` are valid after edge N+k.
  - `dmem_req` and `halt` go low after edge N+k.
  - Minimum latency is 2 cycles.
- `halt` is registered. While `halt` = 1, upstream holds `valid_in`, `instruction_in`, `alu_in` and `store_data_in` stable, and the stage does not sample them.
- An ack arriving in the same cycle as `rst` is discarded.
- When no instruction is produced, `valid_out` = 0 and the other outputs hold their last values.
- `dmem_ack` while IDLE is ignored.

## Test plan

- **ADDI pass-through.** ADDI with `alu_in` = 0x0000_0042 → one cycle later `valid_out` = 1, `result_out` = 0x42, `instruction_out` equal to the input, `dmem_req` never asserted.
- **LB sign extension with wait.** LB at address 0x103 with `dmem_rdata` = 0x80AB_CDEF and ack after 3 wait cycles → `dmem_addr` = 0x100, `dmem_be` = 4'b1000, `halt` high for 4 cycles, `result_out` = 0xFFFF_FF80. Repeat with LBU → `result_out` = 0x0000_0080.
- **SH lane replication.** SH at 0x202 with `rs2` = 0x1234_BEEF → `dmem_we` = 1, `dmem_be` = 4'b1100, `dmem_wdata` = 0xBEEF_BEEF, `result_out` = 0.
- **Misaligned word load.** LW at 0x101 → `misalign_err` pulses for one cycle, `dmem_req` stays 0, `instruction_out` = 0x0000_0013, `result_out` = 0.
- **Branch squash.** `taken_branch` = 1 with a valid SW → no request, `NOP` emitted. `taken_branch` pulsed while BUSY → the access still completes with correct data.
- **Reset mid-transaction.** `rst` asserted during BUSY → the next cycle shows `dmem_req` = 0, `halt` = 0, `valid_out` = 0, state IDLE. A following LW at 0x0 with ack and `dmem_rdata` = 0xDEAD_BEEF → `result_out` = 0xDEAD_BEEF.

Source files
------------

// File: rtl/mem_access.sv
// RV32I memory-access stage: ALU pass-through, aligned loads/stores over a req/ack port, load lane extract/extend.
// Latency: 1 cycle for non-memory, squash and misaligned cases; at least 2 cycles for memory. Registered halt is held while a request is outstanding.
module mem_access #(
    parameter int              XLEN = 32,
    parameter logic [XLEN-1:0] NOP  = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_in,
    input  logic [XLEN-1:0] instruction_in,
    input  logic [XLEN-1:0] alu_in,
    input  logic [XLEN-1:0] store_data_in,
    input  logic            taken_branch,
    output logic            halt,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [3:0]      dmem_be,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ack,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            valid_out,
    output logic [XLEN-1:0] instruction_out,
    output logic [XLEN-1:0] result_out,
    output logic            misalign_err
);
    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    state_t          state_q, state_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [1:0]      off_q, off_d;
    logic [2:0]      f3_q, f3_d;
    logic            we_q, we_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [3:0]      be_q, be_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic            valid_out_q, valid_out_d;
    logic [XLEN-1:0] instr_out_q, instr_out_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            misalign_q, misalign_d;

    logic            is_load, is_store, misaligned;
    logic [2:0]      f3;
    logic [1:0]      off;
    logic [3:0]      be_calc;
    logic [XLEN-1:0] wdata_calc, lane, load_val;

    always_comb begin
        is_load  = (instruction_in[6:0] == OP_LOAD);
        is_store = (instruction_in[6:0] == OP_STORE);
        f3       = instruction_in[14:12];
        off      = alu_in[1:0];

        // funct3[1:0] is the access size; size 3 and unsigned stores/words are illegal
        case (f3[1:0])
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = off[0];
            2'b10:   misaligned = (off != 2'b00);
            default: misaligned = 1'b1;
        endcase
        if (f3[2] && (is_store || f3[1])) misaligned = 1'b1;

        case (f3[1:0])
            2'b00:   be_calc = 4'b0001 << off;
            2'b01:   be_calc = 4'b0011 << off;
            default: be_calc = 4'b1111;
        endcase

        case (f3[1:0])
            2'b00:   wdata_calc = {4{store_data_in[7:0]}};
            2'b01:   wdata_calc = {2{store_data_in[15:0]}};
            default: wdata_calc = store_data_in;
        endcase

        lane = dmem_rdata >> {off_q, 3'b000};
        case (f3_q)
            3'b000:  load_val = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_val = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_val = {24'h0, lane[7:0]};
            3'b101:  load_val = {16'h0, lane[15:0]};
            default: load_val = lane;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        off_d       = off_q;
        f3_d        = f3_q;
        we_d        = we_q;
        addr_d      = addr_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        valid_out_d = 1'b0;
        instr_out_d = instr_out_q;
        result_d    = result_q;
        misalign_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    valid_out_d = 1'b1;
                    if (taken_branch) begin
                        instr_out_d = NOP;
                        result_d    = '0;
                    end else if (is_load || is_store) begin
                        if (misaligned) begin
                            misalign_d  = 1'b1;
                            instr_out_d = NOP;
                            result_d    = '0;
                        end else begin
                            valid_out_d = 1'b0;
                            state_d     = BUSY;
                            instr_d     = instruction_in;
                            off_d       = off;
                            f3_d        = f3;
                            we_d        = is_store;
                            addr_d      = {alu_in[XLEN-1:2], 2'b00};
                            be_d        = be_calc;
                            wdata_d     = wdata_calc;
                        end
                    end else begin
                        instr_out_d = instruction_in;
                        result_d    = alu_in;
                    end
                end
            end
            BUSY: begin
                // taken_branch is deliberately not looked at: the access must finish
                if (dmem_ack) begin
                    state_d     = IDLE;
                    valid_out_d = 1'b1;
                    instr_out_d = instr_q;
                    result_d    = we_q ? '0 : load_val;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            instr_q     <= NOP;
            off_q       <= '0;
            f3_q        <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            valid_out_q <= 1'b0;
            instr_out_q <= NOP;
            result_q    <= '0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            off_q       <= off_d;
            f3_q        <= f3_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            valid_out_q <= valid_out_d;
            instr_out_q <= instr_out_d;
            result_q    <= result_d;
            misalign_q  <= misalign_d;
        end
    end

    assign halt            = (state_q == BUSY);
    assign dmem_req        = (state_q == BUSY);
    assign dmem_we         = we_q;
    assign dmem_addr       = addr_q;
    assign dmem_be         = be_q;
    assign dmem_wdata      = wdata_q;
    assign valid_out       = valid_out_q;
    assign instruction_out = instr_out_q;
    assign result_out      = result_q;
    assign misalign_err    = misalign_q;
endmodule
